// File: rtl/scsi_arb_pkg.sv
// Shared types for the SCSI access-path arbiter: FSM state encoding and default widths.
package scsi_arb_pkg;

  localparam int CNT_W_DEF = 24;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CPU_CYC  = 3'd1,
    CPU_END  = 3'd2,
    DMA_RUN  = 3'd3,
    DMA_END  = 3'd4,
    FLUSH_ST = 3'd5
  } arb_state_e;

endpackage

// File: rtl/xfer_cnt.sv
// Loadable longword down counter that sticks at zero; load beats decrement.
module xfer_cnt
  import scsi_arb_pkg::*;
#(
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             CPUCLK,
  input  logic             RESET,
  input  logic             load,
  input  logic [CNT_W-1:0] load_val,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             zero,
  output logic             nxt_zero
);

  logic [CNT_W-1:0] cnt_nxt;

  always_comb begin
    cnt_nxt = cnt;
    if (load) begin
      cnt_nxt = load_val;
    end else if (dec && (cnt != '0)) begin
      cnt_nxt = cnt - 1'b1;
    end
  end

  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      cnt <= '0;
    end else begin
      cnt <= cnt_nxt;
    end
  end

  assign zero     = (cnt == '0);
  assign nxt_zero = (cnt_nxt == '0);

endmodule

// File: rtl/scsi_xfer_arb.sv
// Arbitrates CPU register cycles against DMA bursts on the shared SCSI state machine
// path, tracks the DMA transfer count and sequences FIFO flushes.
module scsi_xfer_arb
  import scsi_arb_pkg::*;
#(
  parameter int CNT_W    = CNT_W_DEF,
  parameter int BURST_LW = 4,
  parameter int GAP      = 2
) (
  input  logic             CPUCLK,
  input  logic             RESET,
  input  logic             CPU_ACC,
  input  logic             CPU_DONE,
  input  logic             DMAENA,
  input  logic             DREQ_,
  input  logic             LW_DONE,
  input  logic             FIFOEMPTY,
  input  logic             TC_LOAD,
  input  logic [CNT_W-1:0] TC_VAL,
  input  logic             FLUSH,
  output logic             CPUREQ,
  output logic             GDREQ_,
  output logic             DMA_GNT,
  output logic             TC_ZERO,
  output logic             FLUSH_DONE,
  output logic             BUSY,
  output arb_state_e       DBG_STATE,
  output logic [CNT_W-1:0] DBG_COUNT
);

  localparam int BW = $clog2(BURST_LW + 1);
  localparam int GW = $clog2(GAP + 1);

  arb_state_e      state, state_nxt;
  logic [BW-1:0]   burst_q;
  logic [GW-1:0]   gap_q;
  logic            flush_pend_q;
  logic            lw_cnt;
  logic            burst_max;
  logic            tc_zero;
  logic            nxt_zero;
  logic [CNT_W-1:0] cnt;

  // A longword is only ours to count while the path is (or was just) granted to DMA.
  assign lw_cnt    = LW_DONE && ((state == DMA_RUN) || (state == DMA_END));
  assign burst_max = (burst_q >= BW'(BURST_LW));

  xfer_cnt #(.CNT_W(CNT_W)) u_cnt (
    .CPUCLK   (CPUCLK),
    .RESET    (RESET),
    .load     (TC_LOAD),
    .load_val (TC_VAL),
    .dec      (lw_cnt),
    .cnt      (cnt),
    .zero     (tc_zero),
    .nxt_zero (nxt_zero)
  );

  assign TC_ZERO   = tc_zero;
  assign DBG_COUNT = cnt;
  assign DBG_STATE = state;

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: begin
        if (CPU_ACC) begin
          state_nxt = CPU_CYC;
        end else if (DMAENA && !tc_zero && (gap_q == '0)) begin
          state_nxt = DMA_RUN;
        end else if (FLUSH || flush_pend_q) begin
          state_nxt = FLUSH_ST;
        end
      end
      CPU_CYC: begin
        if (CPU_DONE) state_nxt = CPU_END;
      end
      CPU_END: begin
        if (!CPU_DONE && !CPU_ACC) state_nxt = IDLE;
      end
      DMA_RUN: begin
        // A pending CPU preempts immediately when the SCSI IC stops asking for data.
        if (nxt_zero || !DMAENA || (CPU_ACC && (DREQ_ || burst_max))) begin
          state_nxt = DMA_END;
        end
      end
      DMA_END: begin
        state_nxt = IDLE;
      end
      FLUSH_ST: begin
        if (FIFOEMPTY) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge CPUCLK) begin
    if (RESET) begin
      state        <= IDLE;
      burst_q      <= '0;
      gap_q        <= '0;
      flush_pend_q <= 1'b0;
      CPUREQ       <= 1'b0;
      GDREQ_       <= 1'b1;
      DMA_GNT      <= 1'b0;
      FLUSH_DONE   <= 1'b0;
      BUSY         <= 1'b0;
    end else begin
      state <= state_nxt;

      if (state == DMA_END) begin
        burst_q <= '0;
      end else if ((state == DMA_RUN) && LW_DONE && !burst_max) begin
        burst_q <= burst_q + 1'b1;
      end

      if ((state == CPU_END) && (state_nxt == IDLE)) begin
        gap_q <= GW'(GAP);
      end else if ((state == IDLE) && (gap_q != '0)) begin
        gap_q <= gap_q - 1'b1;
      end

      if ((state == DMA_RUN) && FLUSH) begin
        flush_pend_q <= 1'b1;
      end else if ((state == IDLE) && (state_nxt == FLUSH_ST)) begin
        flush_pend_q <= 1'b0;
      end

      CPUREQ     <= (state == CPU_CYC);
      DMA_GNT    <= (state == DMA_RUN) || (state == DMA_END);
      GDREQ_     <= (state == DMA_RUN) ? DREQ_ : 1'b1;
      FLUSH_DONE <= (state == FLUSH_ST) && FIFOEMPTY;
      BUSY       <= (state != IDLE);
    end
  end

endmodule
